// File: rtl/sha3_pkg.sv
// Shared constants and state encoding for the SHA-3 input padder.
package sha3_pkg;

    localparam int RATE_WORDS = 18;

    localparam logic [7:0] PAD_START = 8'h01;
    localparam logic [7:0] PAD_END   = 8'h80;

    typedef enum logic [1:0] {
        ACCEPT  = 2'd0,
        PADFILL = 2'd1,
        FULL    = 2'd2
    } state_t;

endpackage

// File: rtl/padder1.sv
// Final-word formatter: keeps the first byte_num bytes, inserts the 0x01
// pad byte right after them and zeroes the rest.
module padder1
    import sha3_pkg::*;
(
    input  logic [31:0] in,
    input  logic [1:0]  byte_num,
    output logic [31:0] out
);

    always_comb begin
        out = '0;
        unique case (byte_num)
            2'd0: out = {PAD_START, 24'h000000};
            2'd1: out = {in[31:24], PAD_START, 16'h0000};
            2'd2: out = {in[31:16], PAD_START, 8'h00};
            2'd3: out = {in[31:8], PAD_START};
            default: out = '0;
        endcase
    end

endmodule

// File: rtl/padder.sv
// Collects 32-bit message words into one rate-sized block and appends the
// SHA-3 pad (0x01 ... 0x80) so that it always ends in the current block.
//
// state   | meaning
// ACCEPT  | taking message words from the producer
// PADFILL | message ended early; shifting in zero words until the block is full
// FULL    | block complete on out; waiting for f_ack
module padder
    import sha3_pkg::*;
#(
    parameter int RATE_WORDS = sha3_pkg::RATE_WORDS
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [31:0]             in,
    input  logic                    in_ready,
    input  logic                    is_last,
    input  logic [1:0]              byte_num,
    output logic                    buffer_full,
    output logic [32*RATE_WORDS-1:0] out,
    output logic                    out_ready,
    output logic                    out_last,
    input  logic                    f_ack
);

    localparam int CNT_W = $clog2(RATE_WORDS + 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic             done;
    logic [31:0]      in_padded;
    logic [31:0]      shift_word;
    logic             shift_en;
    logic             last_taken;
    logic             clr;
    logic             at_end;

    padder1 u_padder1 (
        .in       (in),
        .byte_num (byte_num),
        .out      (in_padded)
    );

    assign at_end = (count == CNT_W'(RATE_WORDS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ACCEPT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        shift_word = '0;
        last_taken = 1'b0;
        clr        = 1'b0;
        unique case (state)
            ACCEPT: begin
                if (in_ready) begin
                    shift_en   = 1'b1;
                    last_taken = is_last;
                    shift_word = is_last ? in_padded : in;
                    // the closing 0x80 only belongs to the final block
                    if (is_last && at_end) begin
                        shift_word[7:0] = shift_word[7:0] | PAD_END;
                    end
                    if (at_end) begin
                        state_next = FULL;
                    end else if (is_last) begin
                        state_next = PADFILL;
                    end
                end
            end
            PADFILL: begin
                shift_en = 1'b1;
                if (at_end) begin
                    shift_word[7:0] = PAD_END;
                    state_next      = FULL;
                end
            end
            FULL: begin
                if (f_ack) begin
                    clr        = 1'b1;
                    state_next = ACCEPT;
                end
            end
            default: state_next = ACCEPT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            out   <= '0;
            done  <= 1'b0;
        end else begin
            if (clr) begin
                count <= '0;
                done  <= 1'b0;
            end else if (shift_en) begin
                count <= count + 1'b1;
                out   <= {out[32*RATE_WORDS-33:0], shift_word};
                if (last_taken) begin
                    done <= 1'b1;
                end
            end
        end
    end

    assign out_ready   = (state == FULL);
    assign buffer_full = (state != ACCEPT);
    assign out_last    = out_ready && done;

endmodule

// File: doc/padder.md
PADDER -- requirements
Module: padder

Interface
REQ-001 Parameter RATE_WORDS, default 18, is the number of 32-bit words per block (576-bit rate).
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 in  input  32  message word; first message byte in bits 31:24.
REQ-005 in_ready  input  1  in holds a valid word this cycle.
REQ-006 is_last  input  1  in is the final message word; qualified by in_ready.
REQ-007 byte_num  input  2  valid bytes in the final word (0..3); meaningful only with is_last.
REQ-008 buffer_full  output  1  stall: no word is accepted this cycle.
REQ-009 out  output  32*RATE_WORDS  assembled block; word 0 in the MSBs.
REQ-010 out_ready  output  1  out holds a complete block.
REQ-011 out_last  output  1  the presented block is the final, padded block of the message.
REQ-012 f_ack  input  1  consumer has taken out; qualified by out_ready.

Function
REQ-013 States SHALL be ACCEPT, PADFILL, FULL; FULL is entered when the word count reaches RATE_WORDS.
REQ-014 out_ready SHALL equal (state == FULL); buffer_full SHALL equal (state != ACCEPT).
REQ-015 A word SHALL be accepted iff in_ready && state == ACCEPT, sampled on pre-edge values; accepting shifts it into the low word of the buffer and increments the count.
REQ-016 An accepted word with is_last = 0 SHALL be stored unmodified.
REQ-017 An accepted word with is_last = 1 SHALL keep its first byte_num bytes, place 0x01 in the next byte and zero the remaining bytes (byte_num 0 -> 0x01000000; byte_num 3 -> in[31:8],0x01).
REQ-018 After the is_last word, if the count < RATE_WORDS, the state SHALL be PADFILL; in PADFILL one zero word SHALL be shifted in per cycle with in/in_ready ignored.
REQ-019 The word written into position RATE_WORDS-1 of the final block SHALL have 0x80 OR-ed into bits 7:0, including when it is the is_last word (byte_num 3 gives low byte 0x81).
REQ-020 Padding SHALL always fit in the current block; no extra block is ever generated.
REQ-021 out_last SHALL be 1 while a FULL block contains the padding, else 0.
REQ-022 f_ack with out_ready SHALL clear the count and return to ACCEPT the next cycle; f_ack without out_ready SHALL be ignored.
REQ-023 A word presented in the f_ack cycle SHALL NOT be accepted; the producer holds it until buffer_full drops.
REQ-024 After the final block is acknowledged, the next accepted word SHALL start a new message at count 0.
REQ-025 Latency: out_ready SHALL rise on the cycle after the edge that stores word RATE_WORDS-1.

Reset
REQ-026 reset_n low SHALL asynchronously force state ACCEPT, count 0, out all-zero, out_ready 0, out_last 0, buffer_full 0.
REQ-027 Reset mid-block or mid-PADFILL SHALL discard all partial data; no block is emitted.
REQ-028 Deassertion SHALL take effect at the next clk edge; the first word is accepted no earlier than that edge.

Structure
REQ-029 RATE_WORDS, the state encoding and the pad bytes 0x01/0x80 SHALL reside in the shared package sha3_pkg.
REQ-030 The byte_num-driven 0x01 insertion SHALL be the combinational sub-module padder1; all sequential logic stays in padder.

Verification
REQ-031 18 words 0x00000001..0x00000012 with is_last=0 -> out_ready=1, out_last=0, word 17 = 0x00000012; f_ack -> out_ready=0 the next cycle.
REQ-032 One word 0x11223344, is_last=1, byte_num=2 -> word 0 = 0x11220100, words 1-16 = 0, word 17 = 0x00000080, out_last=1 after 17 PADFILL cycles.
REQ-033 17 data words then 18th word 0xAABBCCDD, is_last=1, byte_num=3 -> word 17 = 0xAABBCC81, out_last=1, no second block.
REQ-034 Block full, in_ready held high with f_ack pulse -> held word not accepted in the f_ack cycle; accepted as word 0 the cycle after.
REQ-035 reset_n pulsed low after 5 words -> out = 0 and out_ready = 0 immediately; a following 18-word message yields a clean block.
REQ-036 is_last, byte_num=0 as word 0 -> word 0 = 0x01000000, word 17 = 0x00000080.
